// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the instruction fetch front end.
//   - fetch_state_e    : fetch FSM state encoding
//   - NOP_INS          : canonical RISC-V nop (addi x0,x0,0), handy for benches
//   - DEFAULT_RESET_PC : default PC loaded on reset
//   Optional feature macro: FETCH_MISALIGN_TRAP_EN (ST_FAULT is only reachable
//   when it is defined).
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam logic [31:0] NOP_INS          = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_next_gen.sv
// -----------------------------------------------------------------------------
// pc_next_gen
//   Combinational next-PC selection for the fetch unit.
//   Ports:
//     pc            in   current PC register value
//     pcsel         in   1 = take the ALU target, 0 = sequential
//     alu_target    in   branch/jump target from the ALU
//     pc_next       out  selected next PC (target has bit 0 cleared for jalr)
//     pc_plus4      out  pc + 4, also the jal/jalr link value
//     misalign_next out  next PC is not 4-byte aligned (bit 1 set)
// -----------------------------------------------------------------------------
module pc_next_gen #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              pcsel,
    input  logic [ADDR_W-1:0] alu_target,
    output logic [ADDR_W-1:0] pc_next,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              misalign_next
);

    localparam logic [ADDR_W-1:0] CLR_BIT0 = {{(ADDR_W-1){1'b1}}, 1'b0};

    logic [ADDR_W-1:0] target;

    // Wraps modulo 2^ADDR_W by construction.
    assign pc_plus4      = pc + ADDR_W'(4);
    // jalr requires bit 0 of the computed target to be cleared.
    assign target        = alu_target & CLR_BIT0;
    assign pc_next       = pcsel ? target : pc_plus4;
    // Bit 0 is always clear here, so bit 1 alone decides word misalignment.
    assign misalign_next = pc_next[1];

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Instruction fetch front end: owns the PC, fetches from a variable-latency
//   instruction memory and presents one instruction at a time to the decoder.
//   Sequence per instruction: REQ (until imem_ack) -> VALID (until hold=0).
//   Optional macro: FETCH_MISALIGN_TRAP_EN adds a FAULT state and the sticky
//   `misalign` output; a misaligned next PC then parks the unit until reset.
//   Ports:
//     clk, rst_n           clock, synchronous active-low reset
//     imem_req/imem_addr   memory request (addr = pc, combinational)
//     imem_ack/imem_rdata  memory response, only honoured in REQ
//     ins/iready/pc        instruction presented to the decoder
//     pc_plus4             pc + 4 link value (combinational)
//     pcsel/alu_target     next-PC redirect, sampled in VALID with hold=0
//     hold                 execute stall, freezes the VALID instruction
//     misalign             sticky fault flag (macro builds only)
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       ins,
    output logic              iready,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              pcsel,
    input  logic [ADDR_W-1:0] alu_target,
`ifdef FETCH_MISALIGN_TRAP_EN
    input  logic              hold,
    output logic              misalign
`else
    input  logic              hold
`endif
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ins_q, ins_d;
    logic              iready_q, iready_d;
    logic              imem_req_q, imem_req_d;
    logic [ADDR_W-1:0] pc_next;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic              misalign_q, misalign_d;
    logic              misalign_next;
`endif

    pc_next_gen #(
        .ADDR_W (ADDR_W)
    ) u_pc_next_gen (
        .pc            (pc_q),
        .pcsel         (pcsel),
        .alu_target    (alu_target),
        .pc_next       (pc_next),
        .pc_plus4      (pc_plus4),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misalign_next (misalign_next)
`else
        .misalign_next ()
`endif
    );

    // Output flags are computed from the *next* state so they come straight
    // off flops and line up with the state they describe.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ins_d      = ins_q;
        iready_d   = iready_q;
        imem_req_d = imem_req_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            ST_IDLE: begin
                state_d    = ST_REQ;
                imem_req_d = 1'b1;
                iready_d   = 1'b0;
            end
            ST_REQ: begin
                if (imem_ack) begin
                    ins_d      = imem_rdata;
                    state_d    = ST_VALID;
                    imem_req_d = 1'b0;
                    iready_d   = 1'b1;
                end
            end
            ST_VALID: begin
                // hold=1 keeps everything as is (defaults above).
                if (!hold) begin
                    pc_d       = pc_next;
                    iready_d   = 1'b0;
                    state_d    = ST_REQ;
                    imem_req_d = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
                    // PC still advances so the faulting address is visible.
                    if (misalign_next) begin
                        state_d    = ST_FAULT;
                        imem_req_d = 1'b0;
                        misalign_d = 1'b1;
                    end
`endif
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_FAULT: begin
                // Parked until reset.
                imem_req_d = 1'b0;
                iready_d   = 1'b0;
            end
`endif
            default: begin
                state_d    = ST_IDLE;
                imem_req_d = 1'b0;
                iready_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            ins_q      <= 32'h0000_0000;
            iready_q   <= 1'b0;
            imem_req_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ins_q      <= ins_d;
            iready_q   <= iready_d;
            imem_req_q <= imem_req_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign ins       = ins_q;
    assign iready    = iready_q;
    assign pc        = pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign  = misalign_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Randomised bench for instr_fetch_unit with a reactive memory model and a
//   transaction-level reference: it tracks the expected PC stream, whether an
//   instruction or a request should be visible each cycle, and the expected
//   fetch latency (1 release/IDLE cycle + 1 + wait cycles).
//   Build with FETCH_MISALIGN_TRAP_EN to also exercise the fault trap.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NO_PC  = 32'h0000_0001; // never an expected PC

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] ins;
    logic        iready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pcsel = 1'b0;
    logic [31:0] alu_target = 32'h0;
    logic        hold = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    instr_fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ins        (ins),
        .iready     (iready),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .pcsel      (pcsel),
        .alu_target (alu_target),
`ifdef FETCH_MISALIGN_TRAP_EN
        .hold       (hold),
        .misalign   (misalign)
`else
        .hold       (hold)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state
    logic [31:0] exp_pc;
    bit          exp_valid;  // next observation should show an instruction
    bit          entering;   // next VALID observation is the first of its fetch
    int          waits;      // memory wait cycles for the current fetch
    int          req_cnt;
    int          hold_left;
    int          rel_cyc;    // cycle the previous fetch was released / reset left
    bit          use_nop = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (use_nop) return NOP_INS;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
        t[1] = 1'b0;
`endif
        return t;
    endfunction

    task automatic do_reset(input int first_wait);
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        hold     = 1'b0;
        pcsel    = 1'b0;
        step();
        step();
        chk("rst_iready", 32'(iready), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_ins", ins, 32'h0);
        chk("rst_imem_addr", imem_addr, RST_PC);
        chk("rst_pc_plus4", pc_plus4, RST_PC + 32'd4);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("rst_misalign", 32'(misalign), 32'd0);
`endif
        rst_n     = 1'b1;
        exp_pc    = RST_PC;
        exp_valid = 1'b0;
        entering  = 1'b0;
        req_cnt   = 0;
        waits     = first_wait;
        rel_cyc   = cyc;
    endtask

    // Runs until n instructions have been released by the decoder side.
    task automatic run(input int n, input int wlo, input int whi, input int hold_pct,
                       input int jump_pct, input logic [31:0] jpc, input logic [31:0] jtgt,
                       input logic [31:0] hpc, input int hn);
        int done = 0;
        int budget = 0;
        logic [31:0] tgt;
        while (done < n && budget < n * 20 + 20) begin
            step();
            budget++;
            imem_ack   = 1'b0;
            hold       = 1'b0;
            pcsel      = 1'($urandom_range(0, 1)); // ignored unless releasing
            alu_target = $urandom;
            chk("iready", 32'(iready), 32'(exp_valid));
            chk("imem_req", 32'(imem_req), 32'(!exp_valid));
            if (exp_valid) begin
                chk("pc", pc, exp_pc);
                chk("ins", ins, mem_word(exp_pc));
                chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
                if (entering) begin
                    chk("latency", 32'(cyc - rel_cyc), 32'(waits + 2));
                    entering  = 1'b0;
                    hold_left = (exp_pc == hpc) ? hn :
                                (int'($urandom_range(0, 99)) < hold_pct ? int'($urandom_range(1, 3)) : 0);
                end
                // Stray ack while an instruction is presented must be ignored.
                if ($urandom_range(0, 99) < 20) begin
                    imem_ack   = 1'b1;
                    imem_rdata = $urandom;
                end
                if (hold_left > 0) begin
                    hold = 1'b1;
                    hold_left--;
                end else begin
                    if (exp_pc == jpc || int'($urandom_range(0, 99)) < jump_pct) begin
                        tgt        = (exp_pc == jpc) ? jtgt : rand_target();
                        pcsel      = 1'b1;
                        alu_target = tgt;
                        exp_pc     = {tgt[31:1], 1'b0};
                    end else begin
                        pcsel  = 1'b0;
                        exp_pc = exp_pc + 32'd4;
                    end
                    exp_valid = 1'b0;
                    rel_cyc   = cyc;
                    req_cnt   = 0;
                    waits     = int'($urandom_range(wlo, whi));
                    done++;
                end
            end else begin
                chk("imem_addr", imem_addr, exp_pc);
                if (req_cnt == waits) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(exp_pc);
                    exp_valid  = 1'b1;
                    entering   = 1'b1;
                end
                req_cnt++;
            end
        end
        if (done < n) chk("timeout", 32'(done), 32'(n));
    endtask

    initial begin
        // Reset, zero-wait NOP memory; first instruction 2 cycles after release.
        do_reset(0);
        run(1, 3, 3, 0, 0, NO_PC, 32'h0, NO_PC, 0);             // pc 0, next fetch waits 3
        run(1, 0, 0, 0, 0, NO_PC, 32'h0, NO_PC, 0);             // pc 4 after 3 wait cycles
        run(2, 1, 1, 0, 0, 32'h8, 32'h0000_0101, 32'h100, 3);   // jump at 8 -> 0x100, hold 3

        // Reset during the REQ wait for 0x104 with a late ack in the IDLE cycle.
        step();
        chk("mid_req", 32'(imem_req), 32'd1);
        chk("mid_addr", imem_addr, 32'h0000_0104);
        imem_ack = 1'b0;
        rst_n    = 1'b0;
        step();
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_iready", 32'(iready), 32'd0);
        chk("mid_rst_pc", pc, RST_PC);
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        exp_pc     = RST_PC;
        exp_valid  = 1'b0;
        entering   = 1'b0;
        req_cnt    = 0;
        waits      = 1;
        rel_cyc    = cyc;
        run(3, 0, 2, 0, 0, NO_PC, 32'h0, NO_PC, 0);

        // Randomised traffic: waits, holds, jumps, stray acks.
        use_nop = 1'b0;
        run(300, 0, 4, 30, 30, NO_PC, 32'h0, NO_PC, 0);

`ifdef FETCH_MISALIGN_TRAP_EN
        run(1, 0, 0, 0, 0, exp_pc, 32'h0000_0042, NO_PC, 0);
        step();
        chk("trap_misalign", 32'(misalign), 32'd1);
        chk("trap_pc", pc, 32'h0000_0042);
        for (int i = 0; i < 5; i++) begin
            imem_ack = 1'(i & 1);
            chk("trap_req", 32'(imem_req), 32'd0);
            chk("trap_iready", 32'(iready), 32'd0);
            chk("trap_sticky", 32'(misalign), 32'd1);
            step();
        end
        do_reset(0);
        run(2, 0, 1, 0, 0, NO_PC, 32'h0, NO_PC, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front end for the single-cycle RISC-V core. Owns the PC, issues requests to a variable-latency instruction memory, and presents one instruction at a time to the decoder as `ins` qualified by `iready`. It then takes the decoder's `pcsel` and the ALU target back to select the next PC. It is the producer end of the `ins`/`iready` interface.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
- `ADDR_W`, 32, PC/address width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset; sampled on `clk` rising edge.
- `imem_req`  out  1  instruction memory request; held high until `imem_ack`.
- `imem_addr`  out  ADDR_W  fetch address; equals `pc` while `imem_req`.
- `imem_ack`  in  1  read complete; `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `ins`  out  32  instruction to decoder.
- `iready`  out  1  `ins` valid; the instruction executes in this cycle.
- `pc`  out  ADDR_W  address of `ins`.
- `pc_plus4`  out  ADDR_W  `pc + 4`, the link value for jal/jalr writeback.
- `pcsel`  in  1  from decoder; take `alu_target` as the next PC. Sampled only while `iready`.
- `alu_target`  in  ADDR_W  branch/jump target from the ALU.
- `hold`  in  1  execute stall (e.g. data memory busy); freezes the instruction currently presented.
- `misalign`  out  1  sticky fetch-misalign flag. Present only with `FETCH_MISALIGN_TRAP_EN`.

## Operation
- FSM states: IDLE, REQ, VALID, and FAULT (FAULT exists only with the macro).
- **IDLE**
  - Entered on reset.
  - Always moves to REQ on the next cycle.
  - Drives `imem_req=0` and `iready=0`.
- **REQ**
  - Drives `imem_req=1` and `imem_addr=pc`.
  - On `imem_ack`: latch `ins<=imem_rdata`, go to VALID.
  - Otherwise stay in REQ.
- **VALID**
  - Drives `iready=1` and `imem_req=0`.
  - If `hold=1`: stay in VALID; `ins`, `pc` and `iready` are unchanged.
  - If `hold=0`:
    - Next PC = `pcsel ? {alu_target[ADDR_W-1:1],1'b0} : pc+4`. jalr bit-0 clearing is done here.
    - Go to REQ with the new `pc`.
- Arithmetic is modulo 2^ADDR_W: `pc+4` wraps from 32'hFFFF_FFFC to 0 silently.
- `pc_plus4` is combinational from the `pc` register.
- `imem_ack` outside REQ is ignored.
- Reset values:
  - `pc=RESET_PC`, state IDLE, `ins=32'h0000_0000`, `iready=0`, `imem_req=0`, `imem_addr=RESET_PC`, `misalign=0`.
- Reset mid-fetch: any outstanding request is abandoned and `imem_req` drops at the reset edge. A late ack is ignored because the FSM is in IDLE.
- Reset while in VALID: `iready` drops at the reset edge and the instruction is not retired.

## Timing
- All state and outputs except `pc_plus4` and `imem_addr` are registered.
- With zero-wait memory (`imem_ack` asserted in the first REQ cycle):
  - reset deassert → IDLE (1) → REQ (1) → VALID.
  - First `iready` appears 2 cycles after `rst_n` rises.
- Steady state: 2 cycles per instruction (REQ, VALID). Each memory wait cycle adds 1 cycle.
- `iready` is high for exactly 1 cycle per instruction when `hold=0`.
- `iready` stays high for 1+N cycles for N cycles of `hold`.
- `pcsel` and `alu_target` are sampled only in the VALID cycle where `hold=0`.
- `imem_addr` must be stable for the whole REQ interval.

## Configuration
- Macro: `FETCH_MISALIGN_TRAP_EN`.
- **Defined:**
  - When a computed next PC has bit 1 set, go to FAULT instead of REQ. The PC is still updated.
  - FAULT sets `misalign=1`, keeps `imem_req=0` and `iready=0`, and is exited only by reset.
- **Undefined:**
  - No FAULT state and no `misalign` port.
  - The next PC passes bit 1 unmodified to memory.

## Structure
- Package `fetch_pkg` holds:
  - the FSM state enum;
  - `NOP_INS = 32'h0000_0013`, for benches;
  - the default `RESET_PC` constant.
- One combinational sub-module, `pc_next_gen`, takes `pc`, `pcsel` and `alu_target` and produces `pc_next`, `pc_plus4` and `misalign_next`.

## Test plan
- Reset release, memory acks every request immediately with word 32'h0000_0013:
  - `iready` first high 2 cycles after `rst_n` rises, with `pc=0`;
  - then `pc` = 4, 8, 12 on every second cycle.
- Memory acks after 3 wait cycles: `imem_addr` stays stable at 4 for all 4 REQ cycles, and `iready` for pc=4 appears 5 cycles after the previous one.
- `pcsel=1` with `alu_target=32'h0000_0101` at pc=8:
  - next fetch address is 32'h0000_0100;
  - `pc_plus4` read as 12 during the jump instruction.
- `hold=1` for 3 cycles while in VALID at pc=16: `iready`, `ins` and `pc` are held for 4 cycles, then the fetch moves on to 20.
- `rst_n=0` during the REQ wait for pc=24, with an ack arriving in the cycle after reset:
  - the ack is ignored;
  - the next fetch is to `RESET_PC`.
- With `FETCH_MISALIGN_TRAP_EN`: jump to 32'h0000_0042.
  - `misalign` rises at the next edge.
  - No further `imem_req` or `iready` until reset.
